// File: rtl/mmio_pkg.sv
// Shared bus command encodings, default register addresses and TX FSM state type
// for the memory-mapped UART transmitter.
package mmio_pkg;

  localparam logic [1:0] MWRITE = 2'b01;
  localparam logic [1:0] MREAD  = 2'b11;

  localparam logic [8:0] DEF_TX_ADDR   = 9'h180;
  localparam logic [8:0] DEF_STAT_ADDR = 9'h181;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with power-of-two depth; a push while full is accepted
// only when a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (PTR_W + 1)'(DEPTH));
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = r_mem[r_rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is left unreset; occupancy is tracked by the counter, so stale bytes are never read.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// CPU-bus UART transmitter: store-strobe decode, byte FIFO, 8N1 serialiser and
// a combinational status word merged onto the shared read-data bus.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int         data_width   = 16,
  parameter int         CLKS_PER_BIT = 434,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [8:0] TX_ADDR      = DEF_TX_ADDR,
  parameter logic [8:0] STAT_ADDR    = DEF_STAT_ADDR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mem_cmd,
  input  logic [8:0]            mem_addr,
  input  logic [data_width-1:0] din,
  output logic [data_width-1:0] rdata,
  output logic                  rdata_en,
  output logic                  tx,
  output logic                  busy
);

  localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t      r_state, w_state_next;
  logic [CNT_W-1:0] r_baud, w_baud_next;
  logic [7:0]       r_shift, w_shift_next;
  logic [2:0]       r_idx, w_idx_next;
  logic             r_tx, w_tx_next;
  logic             r_ovf;
  logic             r_tx_cond_q, r_stat_cond_q;

  logic                  w_tx_cond, w_stat_cond;
  logic                  w_wr_tx, w_wr_stat;
  logic                  w_pop, w_full, w_empty;
  logic [7:0]            w_fifo_dout;
  logic                  w_bit_done;
  logic [data_width-1:0] w_status;
  logic                  w_din_unused;

  assign w_din_unused = ^din[data_width-1:8];

  // A store held over several cycles must push only once, hence edge detection.
  assign w_tx_cond   = (mem_cmd == MWRITE) && (mem_addr == TX_ADDR);
  assign w_stat_cond = (mem_cmd == MWRITE) && (mem_addr == STAT_ADDR);
  assign w_wr_tx     = w_tx_cond && !r_tx_cond_q;
  assign w_wr_stat   = w_stat_cond && !r_stat_cond_q;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_wr_tx),
    .pop   (w_pop),
    .din   (din[7:0]),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_cond_q   <= 1'b0;
      r_stat_cond_q <= 1'b0;
      r_ovf         <= 1'b0;
    end else begin
      r_tx_cond_q   <= w_tx_cond;
      r_stat_cond_q <= w_stat_cond;
      if (w_wr_tx && w_full && !w_pop) r_ovf <= 1'b1;
      else if (w_wr_stat)              r_ovf <= 1'b0;
    end
  end

  assign busy     = (r_state != IDLE) || !w_empty;
  assign w_status = {{(data_width - 3){1'b0}}, r_ovf, w_full, busy};
  assign rdata_en = (mem_cmd == MREAD) && (mem_addr == STAT_ADDR);
  assign rdata    = rdata_en ? w_status : {data_width{1'bz}};

  assign w_bit_done = (r_baud == BAUD_LAST);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = w_bit_done ? '0 : r_baud + 1'b1;
    w_shift_next = r_shift;
    w_idx_next   = r_idx;
    w_pop        = 1'b0;
    w_tx_next    = 1'b1;

    case (r_state)
      IDLE: begin
        w_baud_next = '0;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_fifo_dout;
          w_state_next = START;
        end
      end
      START: begin
        if (w_bit_done) begin
          w_idx_next   = '0;
          w_state_next = DATA;
        end
      end
      DATA: begin
        if (w_bit_done) begin
          w_shift_next = r_shift >> 1;
          w_idx_next   = r_idx + 1'b1;
          if (r_idx == 3'd7) w_state_next = STOP;
        end
      end
      STOP: begin
        if (w_bit_done) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase

    // The line level is derived from the upcoming state so tx can leave a flop.
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_shift <= '0;
      r_idx   <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_shift <= w_shift_next;
      r_idx   <= w_idx_next;
      r_tx    <= w_tx_next;
    end
  end

  assign tx = r_tx;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised bench for mmio_uart_tx: a line monitor decodes 8N1 frames and each
// scenario compares them against byte queues and timing derived from the bus writes.
module tb_mmio_uart_tx;
  import mmio_pkg::*;

  localparam int DW    = 16;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    mem_cmd = 2'b00;
  logic [8:0]    mem_addr = 9'h000;
  logic [DW-1:0] din = '0;
  wire  [DW-1:0] rdata;
  wire           rdata_en;
  wire           tx;
  wire           busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] rx_q[$];
  logic       rx_stop_q[$];
  int         rx_start_q[$];

  bit         mon_active = 1'b0;
  int         mon_n      = 0;
  int         mon_start  = 0;
  int         mon_glitch = 0;
  logic       mon_level  = 1'b1;
  logic [9:0] mon_frame  = '0;

  mmio_uart_tx #(
    .data_width   (DW),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .TX_ADDR      (9'h180),
    .STAT_ADDR    (9'h181)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_cmd  (mem_cmd),
    .mem_addr (mem_addr),
    .din      (din),
    .rdata    (rdata),
    .rdata_en (rdata_en),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Line monitor: sample each bit mid-period, flag any level change inside a bit.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && tx == 1'b0) begin
        mon_active = 1'b1;
        mon_n      = 0;
        mon_start  = cyc;
      end
      if (mon_active) begin
        if (mon_n % CPB == 0) mon_level = tx;
        else if (tx !== mon_level) mon_glitch++;
        if (mon_n % CPB == CPB / 2) mon_frame[mon_n / CPB] = tx;
        if (mon_n == FRAME - 1) begin
          rx_q.push_back(mon_frame[8:1]);
          rx_stop_q.push_back(mon_frame[9]);
          rx_start_q.push_back(mon_start);
          mon_active = 1'b0;
        end else begin
          mon_n++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic bus_write(input logic [8:0] addr, input logic [15:0] data);
    mem_cmd  = MWRITE;
    mem_addr = addr;
    din      = data;
  endtask

  task automatic bus_idle();
    mem_cmd  = 2'b00;
    mem_addr = 9'h000;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (rx_q.size() >= n);
  endtask

  task automatic test_reset();
    int bad;
    @(negedge clk);
    n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (rdata_en !== 1'b0) $display("FAIL reset_rdata_en: got %b expected 0", rdata_en); else n_pass++;
    reset = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || rdata_en !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL reset_idle20: got %0d bad cycles expected 0", bad); else n_pass++;
  endtask

  task automatic test_status_read();
    @(negedge clk);
    mem_cmd = MREAD; mem_addr = 9'h181;
    #1;
    n_checks++; if (rdata_en !== 1'b1) $display("FAIL stat_rd_en: got %b expected 1", rdata_en); else n_pass++;
    n_checks++; if (rdata !== 16'h0000) $display("FAIL stat_rd_idle: got %h expected 0000", rdata); else n_pass++;
    @(negedge clk);
    mem_addr = 9'h180;
    #1;
    n_checks++; if (rdata_en !== 1'b0) $display("FAIL stat_rd_txaddr_en: got %b expected 0", rdata_en); else n_pass++;
    @(negedge clk);
    mem_cmd = 2'b10; mem_addr = 9'h181;
    #1;
    n_checks++; if (rdata_en !== 1'b0) $display("FAIL stat_rd_badcmd_en: got %b expected 0", rdata_en); else n_pass++;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_single(input logic [15:0] word);
    int base, d;
    bit ok;
    base = rx_q.size();
    @(negedge clk);
    bus_write(9'h180, word);
    d = cyc;
    @(negedge clk);
    n_checks++; if (tx !== 1'b1) $display("FAIL single_tx_pre: got %b expected 1", tx); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b expected 1", busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (tx !== 1'b0) $display("FAIL single_tx_fall: got %b expected 0", tx); else n_pass++;
    @(negedge clk);
    mem_cmd = MREAD; mem_addr = 9'h181;
    #1;
    n_checks++; if (rdata !== 16'h0001) $display("FAIL single_status: got %h expected 0001", rdata); else n_pass++;
    @(negedge clk);
    bus_idle();
    wait_frames(base + 1, 3 * FRAME, ok);
    n_checks++; if (!ok) $display("FAIL single_timeout: got %0d frames expected %0d", rx_q.size(), base + 1); else n_pass++;
    if (ok) begin
      n_checks++; if (rx_q[base] !== word[7:0]) $display("FAIL single_data: got %h expected %h", rx_q[base], word[7:0]); else n_pass++;
      n_checks++; if (rx_stop_q[base] !== 1'b1) $display("FAIL single_stop: got %b expected 1", rx_stop_q[base]); else n_pass++;
      n_checks++; if (rx_start_q[base] !== d + 2) $display("FAIL single_latency: got start %0d expected %0d", rx_start_q[base], d + 2); else n_pass++;
    end
    repeat (10) @(negedge clk);
    n_checks++; if (rx_q.size() !== base + 1) $display("FAIL single_one_frame: got %0d frames expected %0d", rx_q.size(), base + 1); else n_pass++;
    n_checks++; if (busy !== 1'b0 || tx !== 1'b1) $display("FAIL single_after: got busy=%b tx=%b expected busy=0 tx=1", busy, tx); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0]  b [6];
    logic [7:0]  exp_q[$];
    logic [15:0] exp_stat;
    bit          ovf_exp, ok;
    int          base;
    base    = rx_q.size();
    ovf_exp = 1'b0;
    // All writes land well inside the first frame: one byte in flight plus a full FIFO.
    for (int i = 0; i < 6; i++) begin
      b[i] = 8'($urandom);
      if (exp_q.size() < DEPTH + 1) exp_q.push_back(b[i]);
      else ovf_exp = 1'b1;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus_write(9'h180, {8'($urandom), b[i]});
      @(negedge clk);
      bus_idle();
    end
    @(negedge clk);
    mem_cmd = MREAD; mem_addr = 9'h181;
    #1;
    exp_stat = {13'b0, ovf_exp, (exp_q.size() - 1 == DEPTH), 1'b1};
    n_checks++; if (rdata !== exp_stat) $display("FAIL ovf_status_full: got %h expected %h", rdata, exp_stat); else n_pass++;
    @(negedge clk);
    bus_write(9'h181, 16'($urandom));
    @(negedge clk);
    mem_cmd = MREAD; mem_addr = 9'h181;
    #1;
    exp_stat = {13'b0, 1'b0, (exp_q.size() - 1 == DEPTH), 1'b1};
    n_checks++; if (rdata !== exp_stat) $display("FAIL ovf_status_cleared: got %h expected %h", rdata, exp_stat); else n_pass++;
    @(negedge clk);
    bus_idle();
    wait_frames(base + exp_q.size(), (exp_q.size() + 1) * (FRAME + 1), ok);
    n_checks++; if (!ok) $display("FAIL ovf_timeout: got %0d frames expected %0d", rx_q.size() - base, exp_q.size()); else n_pass++;
    if (ok) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++; if (rx_q[base + i] !== exp_q[i]) $display("FAIL ovf_data%0d: got %h expected %h", i, rx_q[base + i], exp_q[i]); else n_pass++;
      end
    end
    repeat (FRAME + 5) @(negedge clk);
    n_checks++; if (rx_q.size() !== base + exp_q.size()) $display("FAIL ovf_frame_count: got %0d expected %0d", rx_q.size() - base, exp_q.size()); else n_pass++;
    mem_cmd = MREAD; mem_addr = 9'h181;
    #1;
    n_checks++; if (rdata !== 16'h0000) $display("FAIL ovf_status_drained: got %h expected 0000", rdata); else n_pass++;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_back_to_back(input logic [7:0] b0, input logic [7:0] b1);
    int base, d, span;
    bit ok;
    base = rx_q.size();
    @(negedge clk);
    bus_write(9'h180, {8'hA0, b0});
    d = cyc;
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    bus_write(9'h180, {8'h5F, b1});
    @(negedge clk);
    bus_idle();
    wait_frames(base + 2, 3 * FRAME, ok);
    n_checks++; if (!ok) $display("FAIL b2b_timeout: got %0d frames expected 2", rx_q.size() - base); else n_pass++;
    if (ok) begin
      span = rx_start_q[base + 1] + FRAME - rx_start_q[base];
      n_checks++; if (rx_q[base] !== b0 || rx_q[base + 1] !== b1) $display("FAIL b2b_data: got %h,%h expected %h,%h", rx_q[base], rx_q[base + 1], b0, b1); else n_pass++;
      n_checks++; if (rx_start_q[base] !== d + 2) $display("FAIL b2b_first_start: got %0d expected %0d", rx_start_q[base], d + 2); else n_pass++;
      n_checks++; if (span !== 2 * FRAME + 1) $display("FAIL b2b_span: got %0d cycles expected %0d", span, 2 * FRAME + 1); else n_pass++;
      n_checks++; if (rx_stop_q[base] !== 1'b1 || rx_stop_q[base + 1] !== 1'b1) $display("FAIL b2b_stop: got %b%b expected 11", rx_stop_q[base], rx_stop_q[base + 1]); else n_pass++;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_random_stream();
    logic [7:0] b;
    int base, d, gap;
    bit ok;
    for (int i = 0; i < 5; i++) begin
      base = rx_q.size();
      b    = 8'($urandom);
      @(negedge clk);
      bus_write(9'h180, {8'($urandom), b});
      d = cyc;
      @(negedge clk);
      bus_idle();
      wait_frames(base + 1, 2 * FRAME, ok);
      n_checks++; if (!ok) $display("FAIL stream%0d_timeout: got no frame", i); else n_pass++;
      if (ok) begin
        n_checks++; if (rx_q[base] !== b || rx_start_q[base] !== d + 2) $display("FAIL stream%0d: got %h@%0d expected %h@%0d", i, rx_q[base], rx_start_q[base], b, d + 2); else n_pass++;
      end
      gap = $urandom_range(3, 10);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base, d, lows;
    base = rx_q.size();
    @(negedge clk);
    bus_write(9'h180, 16'h00A5);
    d = cyc;
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    bus_write(9'h180, {8'h00, 8'($urandom)});
    @(negedge clk);
    bus_idle();
    while (cyc < d + 11) @(negedge clk);
    n_checks++; if (tx !== 1'b0) $display("FAIL rst_mid_databit1: got %b expected 0", tx); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (tx !== 1'b1) $display("FAIL rst_mid_tx_async: got %b expected 1", tx); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    lows = 0;
    repeat (3 * FRAME) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    n_checks++; if (lows !== 0) $display("FAIL rst_mid_residual: got %0d active cycles expected 0", lows); else n_pass++;
    n_checks++; if (rx_q.size() !== base) $display("FAIL rst_mid_frames: got %0d frames expected 0", rx_q.size() - base); else n_pass++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_status_read();
    test_single(16'hFF41);
    test_single(16'($urandom));
    test_overflow();
    test_back_to_back(8'h00, 8'hFF);
    test_back_to_back(8'($urandom), 8'($urandom));
    test_random_stream();
    test_reset_mid_frame();
    n_checks++; if (mon_glitch !== 0) $display("FAIL line_glitches: got %0d mid-bit changes expected 0", mon_glitch); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
